// File: rtl/iomem_bridge_pkg.sv
// rtl/iomem_bridge_pkg.sv - shared op codes, status codes and FSM states for the iomem bridge
package iomem_bridge_pkg;

  // Command byte op nibble
  localparam logic [3:0] OP_READ       = 4'h1;
  localparam logic [3:0] OP_WRITE      = 4'h2;
  localparam logic [3:0] OP_READ_NEXT  = 4'h5;
  localparam logic [3:0] OP_WRITE_NEXT = 4'h6;

  // First response byte
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_TIMEOUT = 8'hEE;
  localparam logic [7:0] ST_BADOP   = 8'hFF;

  typedef enum logic [2:0] {
    CMD,
    ADDR,
    WDATA,
    BUS,
    RESP
  } state_t;

endpackage

// File: rtl/iomem_bridge_resp_ser.sv
// rtl/iomem_bridge_resp_ser.sv - serialises a status byte plus optional 32-bit word onto a byte stream
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   load                capture status/word; must only pulse while idle
//   status, word        status byte and read word (word sent MSB first)
//   with_word           1 = send 5 bytes, 0 = status byte only
//   out_valid/out_ready/out_data  byte output stream, held stable until accepted
//   done                pulses in the cycle the last byte is accepted
module iomem_bridge_resp_ser (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [7:0]  status,
  input  logic [31:0] word,
  input  logic        with_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        done
);

  logic [39:0] shreg_q;
  logic [2:0]  left_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      left_q  <= '0;
    end else if (load) begin
      shreg_q <= {status, word};
      left_q  <= with_word ? 3'd5 : 3'd1;
    end else if (out_valid && out_ready) begin
      shreg_q <= {shreg_q[31:0], 8'h00};
      left_q  <= left_q - 3'd1;
    end
  end

  assign out_valid = (left_q != 3'd0);
  assign out_data  = shreg_q[39:32];
  assign done      = out_valid && out_ready && (left_q == 3'd1);

endmodule

// File: rtl/iomem_bridge_master.sv
// rtl/iomem_bridge_master.sv - byte-stream command parser driving iomem bus cycles
//
// Optional feature macro: IOMEM_BRIDGE_AUTOINC_EN (read-next / write-next ops using last_addr + 4)
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   in_valid/in_ready/in_data        command byte stream
//   out_valid/out_ready/out_data     response byte stream
//   iomem_valid/iomem_ready          bus request / single-cycle completion pulse
//   iomem_wstrb/addr/wdata/rdata     bus payload (wstrb 0 = read)
//   busy                             high whenever not waiting for a command byte
module iomem_bridge_master
  import iomem_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              iomem_valid,
  input  logic              iomem_ready,
  output logic [3:0]        iomem_wstrb,
  output logic [ADDR_W-1:0] iomem_addr,
  output logic [31:0]       iomem_wdata,
  input  logic [31:0]       iomem_rdata,
  output logic              busy
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        run_q;
  logic [1:0]  byte_cnt_q;
  logic [15:0] wait_cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic        is_write_q;
`ifdef IOMEM_BRIDGE_AUTOINC_EN
  logic [31:0] last_addr_q;
  logic        use_next;
`endif

  logic       in_fire;
  logic [3:0] op;
  logic       take_cmd;
  logic       shift_addr;
  logic       shift_data;
  logic       ser_load;
  logic [7:0] ser_status;
  logic       ser_with_word;
  logic       ser_done;
`ifdef IOMEM_BRIDGE_AUTOINC_EN
  logic       bus_end;
`endif

  assign in_fire = in_valid && in_ready;
  assign op      = in_data[7:4];

  always_ff @(posedge clk) begin
    if (reset) state_q <= CMD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    take_cmd      = 1'b0;
    shift_addr    = 1'b0;
    shift_data    = 1'b0;
    ser_load      = 1'b0;
    ser_status    = ST_OK;
    ser_with_word = 1'b0;
`ifdef IOMEM_BRIDGE_AUTOINC_EN
    use_next      = 1'b0;
    bus_end       = 1'b0;
`endif
    case (state_q)
      CMD: begin
        if (in_fire) begin
          case (op)
            OP_READ, OP_WRITE: begin
              take_cmd = 1'b1;
              state_d  = ADDR;
            end
`ifdef IOMEM_BRIDGE_AUTOINC_EN
            OP_READ_NEXT: begin
              take_cmd = 1'b1;
              use_next = 1'b1;
              state_d  = BUS;
            end
            OP_WRITE_NEXT: begin
              take_cmd = 1'b1;
              use_next = 1'b1;
              state_d  = WDATA;
            end
`endif
            default: begin
              ser_load   = 1'b1;
              ser_status = ST_BADOP;
              state_d    = RESP;
            end
          endcase
        end
      end
      ADDR: begin
        if (in_fire) begin
          shift_addr = 1'b1;
          if (byte_cnt_q == 2'd3) state_d = is_write_q ? WDATA : BUS;
        end
      end
      WDATA: begin
        if (in_fire) begin
          shift_data = 1'b1;
          if (byte_cnt_q == 2'd3) state_d = BUS;
        end
      end
      BUS: begin
        // ready has priority over a timeout landing in the same cycle
        if (iomem_ready) begin
          ser_load      = 1'b1;
          ser_with_word = !is_write_q;
          state_d       = RESP;
`ifdef IOMEM_BRIDGE_AUTOINC_EN
          bus_end       = 1'b1;
`endif
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          ser_load   = 1'b1;
          ser_status = ST_TIMEOUT;
          state_d    = RESP;
`ifdef IOMEM_BRIDGE_AUTOINC_EN
          bus_end    = 1'b1;
`endif
        end
      end
      RESP: begin
        if (ser_done) state_d = CMD;
      end
      default: state_d = CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q       <= 1'b0;
      byte_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      is_write_q  <= 1'b0;
`ifdef IOMEM_BRIDGE_AUTOINC_EN
      last_addr_q <= '0;
`endif
    end else begin
      // delays in_ready by one cycle after reset release
      run_q <= 1'b1;
      if (take_cmd) begin
        is_write_q <= (op == OP_WRITE) || (op == OP_WRITE_NEXT);
        strb_q     <= in_data[3:0];
        byte_cnt_q <= 2'd0;
`ifdef IOMEM_BRIDGE_AUTOINC_EN
        if (use_next) addr_q <= last_addr_q + 32'd4;
`endif
      end
      if (shift_addr) begin
        addr_q     <= {addr_q[23:0], in_data};
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
      if (shift_data) begin
        wdata_q    <= {wdata_q[23:0], in_data};
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
      // counter restarts from zero on every BUS entry
      if (state_q != BUS)    wait_cnt_q <= '0;
      else if (!iomem_ready) wait_cnt_q <= wait_cnt_q + 16'd1;
`ifdef IOMEM_BRIDGE_AUTOINC_EN
      if (bus_end) last_addr_q <= addr_q;
`endif
    end
  end

  iomem_bridge_resp_ser u_resp_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .status    (ser_status),
    .word      (iomem_rdata),
    .with_word (ser_with_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (ser_done)
  );

  assign in_ready    = run_q && (state_q inside {CMD, ADDR, WDATA});
  assign iomem_valid = (state_q == BUS);
  assign iomem_wstrb = (state_q == BUS && is_write_q) ? strb_q : 4'h0;
  assign iomem_addr  = addr_q;
  assign iomem_wdata = wdata_q;
  assign busy        = (state_q != CMD);

endmodule

// File: tb/tb_iomem_bridge_master.sv
// tb/tb_iomem_bridge_master.sv - scoreboard bench for iomem_bridge_master
`timescale 1ns/1ps
module tb_iomem_bridge_master;

  localparam int TMO = 8;

`ifdef IOMEM_BRIDGE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata = 32'h0;
  logic        busy;

  always #5 clk = ~clk;

  iomem_bridge_master #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .busy        (busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ready_at;   // 1-based valid cycle on which ready pulses; 0 = never
    logic [31:0] rdata;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [7:0]  out_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_last_addr = 32'h0;
  bit          hold_out = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Bus responder: checks payload each valid cycle, pulses ready on the planned cycle
  int       rk = 0;
  bit       rhave = 1'b0;
  bus_exp_t rcur;
  initial begin
    forever begin
      @(posedge clk); #1;
      iomem_rdata = $urandom;
      if (reset) begin
        iomem_ready = 1'b0;
        rk = 0;
        rhave = 1'b0;
      end else if (iomem_ready) begin
        iomem_ready = 1'b0;
        rk = 0;
        rhave = 1'b0;
        chk("valid_after_ready", iomem_valid, 0);
      end else if (iomem_valid) begin
        rk++;
        if (rk == 1) begin
          if (bus_q.size() == 0) fail("unexpected_bus_cycle");
          else begin
            rcur = bus_q.pop_front();
            rhave = 1'b1;
          end
        end
        if (rhave) begin
          chk("bus_addr", iomem_addr, rcur.addr);
          chk("bus_wstrb", iomem_wstrb, rcur.wstrb);
          if (rcur.wstrb != 4'h0) chk("bus_wdata", iomem_wdata, rcur.wdata);
          if (rk == rcur.ready_at) begin
            iomem_ready = 1'b1;
            iomem_rdata = rcur.rdata;
          end
        end
      end else if (rk != 0) begin
        chk("valid_high_cycles", rk, TMO);
        rk = 0;
        rhave = 1'b0;
      end
    end
  end

  // Sink back-pressure
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = hold_out ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Output monitor
  bit         stalled = 1'b0;
  logic [7:0] stalled_data = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      if (stalled && !reset) begin
        chk("out_hold_valid", out_valid, 1);
        chk("out_hold_data", out_data, stalled_data);
      end
      stalled = 1'b0;
      if (out_valid && !reset) begin
        if (out_ready) begin
          if (out_q.size() == 0) fail("unexpected_out_byte");
          else chk("out_data", out_data, out_q.pop_front());
        end else begin
          stalled = 1'b1;
          stalled_data = out_data;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 400) begin
        fail("in_ready_wait");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    repeat ($urandom_range(0, 1)) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic bit op_known(input logic [3:0] op);
    return (op == 4'h1) || (op == 4'h2) || (AUTOINC && ((op == 4'h5) || (op == 4'h6)));
  endfunction

  // Reference model: expected bus cycle and response bytes for one frame
  task automatic do_frame(input logic [3:0] op, input logic [3:0] strb, input logic [31:0] addr,
                          input logic [31:0] data, input int ready_at, input logic [31:0] rdata);
    bus_exp_t    e;
    bit          wr, nxt, ok;
    logic [31:0] a;
    if (!op_known(op)) begin
      out_q.push_back(8'hFF);
      send_byte({op, strb});
      return;
    end
    wr  = (op == 4'h2) || (op == 4'h6);
    nxt = (op == 4'h5) || (op == 4'h6);
    a   = nxt ? m_last_addr + 32'd4 : addr;
    ok  = (ready_at >= 1) && (ready_at <= TMO);
    e.addr     = a;
    e.wdata    = data;
    e.wstrb    = wr ? strb : 4'h0;
    e.ready_at = ready_at;
    e.rdata    = rdata;
    bus_q.push_back(e);
    if (!ok) out_q.push_back(8'hEE);
    else begin
      out_q.push_back(8'h00);
      if (!wr) for (int i = 3; i >= 0; i--) out_q.push_back(rdata[8*i +: 8]);
    end
    m_last_addr = a;
    send_byte({op, strb});
    if (!nxt) for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    if (wr)   for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8]);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_iomem_valid", iomem_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_last_addr = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((out_q.size() != 0 || bus_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail("drain_wait");
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [3:0] rnd_ops [12] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h5, 4'h6, 4'h5, 4'h6, 4'h0, 4'h3, 4'h7, 4'hF};

  initial begin
    int n;
    logic [31:0] ra;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_iomem_valid", iomem_valid, 0);
    chk("reset_iomem_wstrb", iomem_wstrb, 0);
    chk("reset_iomem_addr", iomem_addr, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_first_cycle", in_ready, 0);
    @(negedge clk);
    chk("in_ready_second_cycle", in_ready, 1);
    @(posedge clk); #1;

    // Write, responder ready after 3 wait cycles
    do_frame(4'h2, 4'hF, 32'h0300_0000, 32'hDEAD_BEEF, 4, 32'h0);
    wait_idle();

    // Read with sink stalled for 10 cycles on the status byte
    hold_out = 1'b1;
    do_frame(4'h1, 4'h0, 32'h0300_0000, 32'h0, 2, 32'h1234_5678);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail("read_resp_wait");
    repeat (10) begin
      @(negedge clk);
      chk("stalled_valid", out_valid, 1);
      chk("stalled_status", out_data, 8'h00);
    end
    @(posedge clk); #1;
    hold_out = 1'b0;
    wait_idle();

    // Timeout boundaries
    do_frame(4'h1, 4'h0, 32'h0500_0000, 32'h0, 0, 32'h0);
    wait_idle();
    do_frame(4'h1, 4'h0, 32'h0500_0000, 32'h0, TMO, 32'hCAFE_F00D);
    wait_idle();
    do_frame(4'h2, 4'h3, 32'h0500_0010, 32'h0102_0304, TMO + 1, 32'h0);
    wait_idle();

    // Bad op, then a read right behind it
    do_frame(4'h7, 4'h0, 32'h0, 32'h0, 1, 32'h0);
    do_frame(4'h1, 4'h0, 32'h0300_0008, 32'h0, 1, 32'hA5A5_5A5A);
    wait_idle();

    // Reset mid-frame, then a clean write
    send_byte(8'h2F);
    send_byte(8'h03);
    send_byte(8'h00);
    pulse_reset();
    do_frame(4'h2, 4'hF, 32'h0300_0000, 32'h1122_3344, 3, 32'h0);
    wait_idle();

    // Reset mid-bus-cycle: valid must drop at the next edge, no response
    bus_q.push_back('{addr: 32'h0600_0000, wdata: 32'h0, wstrb: 4'h0, ready_at: 0, rdata: 32'h0});
    send_byte(8'h10);
    send_byte(8'h06);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    n = 0;
    while (!iomem_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail("bus_start_wait");
    @(posedge clk); #1;
    pulse_reset();
    wait_idle();

    // Auto-increment ops (answered 0xFF when the feature is absent)
    do_frame(4'h2, 4'hF, 32'h0300_0000, 32'hAAAA_0001, 2, 32'h0);
    do_frame(4'h6, 4'hF, 32'h0, 32'hAAAA_0002, 2, 32'h0);
    do_frame(4'h2, 4'hF, 32'hFFFF_FFFC, 32'hAAAA_0003, 1, 32'h0);
    do_frame(4'h5, 4'hF, 32'h0, 32'h0, 3, 32'h5555_6666);
    wait_idle();

    // Randomised frames
    for (int f = 0; f < 40; f++) begin
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      do_frame(rnd_ops[$urandom_range(0, 11)], 4'($urandom), ra, $urandom,
               $urandom_range(0, TMO + 2), $urandom);
    end
    wait_idle();
    chk("out_queue_empty", out_q.size(), 0);
    chk("bus_queue_empty", bus_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
